// File: rtl/flt_dmac_lookup_scheduler.sv
// ============================================================================
// flt_dmac_lookup_scheduler
//   Shares the single-port 32x57 DMAC forward RAM between config access and a
//   linear lookup scan. Optional statistics counters: FLT_LOOKUP_STAT_EN.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module flt_dmac_lookup_scheduler #(
   parameter int unsigned RAM_RD_LATENCY = 2,
   parameter logic [8:0]  MISS_OUTPORT   = 9'h1FF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_lookup_req,
   input  logic [47:0] iv_dmac,
   output logic        o_lookup_busy,
   output logic        o_lookup_ack,
   output logic        o_hit,
   output logic [8:0]  ov_outport,
   input  logic        i_cfg_wr,
   input  logic        i_cfg_rd,
   input  logic [4:0]  iv_cfg_addr,
   input  logic [56:0] iv_cfg_wdata,
   output logic        o_cfg_rdata_valid,
   output logic [56:0] ov_cfg_rdata,
   output logic [4:0]  ov_ram_addr,
   output logic [56:0] ov_ram_wdata,
   output logic        o_ram_wr,
   output logic        o_ram_rd,
   input  logic [56:0] iv_ram_rdata
`ifdef FLT_LOOKUP_STAT_EN
   ,
   input  logic        i_stat_clr,
   output logic [31:0] ov_hit_cnt,
   output logic [31:0] ov_miss_cnt,
   output logic [31:0] ov_drop_req_cnt
`endif
);

   localparam int unsigned c_L = RAM_RD_LATENCY;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_SCAN  = 2'd1;
   localparam logic [1:0] c_ST_DRAIN = 2'd2;
   localparam logic [1:0] c_ST_DONE  = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [47:0] r_mac;
   logic [4:0]  r_scan_addr;
   logic        r_res_done;

   // Tag stage c_L lines up with iv_ram_rdata
   logic [c_L:0] r_tag_vld;
   logic [c_L:0] r_tag_cfg;
   logic [4:0]   r_tag_addr [c_L+1];

   logic        r_ram_wr;
   logic        r_ram_rd;
   logic [4:0]  r_ram_addr;
   logic [56:0] r_ram_wdata;
   logic        r_cfg_vld;
   logic [56:0] r_cfg_rdata;
   logic        r_ack;
   logic        r_hit;
   logic [8:0]  r_outport;

   logic        w_cfg_any;
   logic        w_cfg_rd;
   logic        w_start;
   logic        w_ret_cfg;
   logic        w_ret_scan;
   logic        w_match;
   logic        w_hit_now;
   logic        w_res_now;
   logic        w_pend;
   logic        w_scan_issue;
   logic [4:0]  w_issue_addr;

   assign w_cfg_any    = i_cfg_wr | i_cfg_rd;
   assign w_cfg_rd     = i_cfg_rd & ~i_cfg_wr;
   assign w_start      = (r_state == c_ST_IDLE) & i_lookup_req;
   assign w_ret_cfg    = r_tag_vld[c_L] & r_tag_cfg[c_L];
   assign w_ret_scan   = r_tag_vld[c_L] & ~r_tag_cfg[c_L] & ~r_res_done &
                         ((r_state == c_ST_SCAN) | (r_state == c_ST_DRAIN));
   assign w_match      = (iv_ram_rdata[8:0] != 9'd0) && (iv_ram_rdata[56:9] == r_mac);
   assign w_hit_now    = w_ret_scan & w_match;
   assign w_res_now    = w_ret_scan & (w_match | (r_tag_addr[c_L] == 5'd31));
   // Scan reads still travelling toward the return stage
   assign w_pend       = |(r_tag_vld[c_L-1:0] & ~r_tag_cfg[c_L-1:0]);
   assign w_scan_issue = ~w_cfg_any & (w_start | ((r_state == c_ST_SCAN) & ~w_hit_now));
   assign w_issue_addr = w_start ? 5'd0 : r_scan_addr;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  if (w_start) w_state_nxt = c_ST_SCAN;
         c_ST_SCAN: begin
            if (w_hit_now || (w_scan_issue && (r_scan_addr == 5'd31)))
               w_state_nxt = c_ST_DRAIN;
         end
         c_ST_DRAIN: if ((r_res_done | w_res_now) & ~w_pend) w_state_nxt = c_ST_DONE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= c_ST_IDLE;
         r_mac       <= '0;
         r_scan_addr <= '0;
         r_res_done  <= 1'b0;
         r_ram_wr    <= 1'b0;
         r_ram_rd    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_cfg_vld   <= 1'b0;
         r_cfg_rdata <= '0;
         r_ack       <= 1'b0;
         r_hit       <= 1'b0;
         r_outport   <= '0;
         r_tag_vld   <= '0;
         r_tag_cfg   <= '0;
         for (int i = 0; i <= int'(c_L); i++) r_tag_addr[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) r_mac <= iv_dmac;

         if (r_state == c_ST_IDLE)
            r_scan_addr <= w_scan_issue ? 5'd1 : 5'd0;
         else if (w_scan_issue)
            r_scan_addr <= r_scan_addr + 5'd1;

         if (w_start || (r_state == c_ST_DONE)) r_res_done <= 1'b0;
         else if (w_res_now)                    r_res_done <= 1'b1;

         // Config owns the port whenever it asks; scan simply slips a cycle
         r_ram_wr <= i_cfg_wr;
         r_ram_rd <= w_cfg_rd | w_scan_issue;
         if (w_cfg_any)         r_ram_addr <= iv_cfg_addr;
         else if (w_scan_issue) r_ram_addr <= w_issue_addr;
         if (i_cfg_wr)          r_ram_wdata <= iv_cfg_wdata;

         r_tag_vld     <= {r_tag_vld[c_L-1:0], w_cfg_rd | w_scan_issue};
         r_tag_cfg     <= {r_tag_cfg[c_L-1:0], w_cfg_rd};
         r_tag_addr[0] <= w_cfg_any ? iv_cfg_addr : w_issue_addr;
         for (int i = 1; i <= int'(c_L); i++) r_tag_addr[i] <= r_tag_addr[i-1];

         r_cfg_vld <= w_ret_cfg;
         if (w_ret_cfg) r_cfg_rdata <= iv_ram_rdata;

         r_ack     <= w_res_now;
         r_hit     <= w_hit_now;
         r_outport <= !w_res_now ? 9'd0 : (w_match ? iv_ram_rdata[8:0] : MISS_OUTPORT);
      end
   end

   assign o_lookup_busy     = (r_state != c_ST_IDLE);
   assign o_lookup_ack      = r_ack;
   assign o_hit             = r_hit;
   assign ov_outport        = r_outport;
   assign o_cfg_rdata_valid = r_cfg_vld;
   assign ov_cfg_rdata      = r_cfg_rdata;
   assign ov_ram_addr       = r_ram_addr;
   assign ov_ram_wdata      = r_ram_wdata;
   assign o_ram_wr          = r_ram_wr;
   assign o_ram_rd          = r_ram_rd;

`ifdef FLT_LOOKUP_STAT_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;
   logic [31:0] r_drop_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_drop_cnt <= '0;
      end else if (i_stat_clr) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (r_ack &  r_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
         if (r_ack & ~r_hit) r_miss_cnt <= r_miss_cnt + 32'd1;
         if (i_lookup_req && (r_state != c_ST_IDLE)) r_drop_cnt <= r_drop_cnt + 32'd1;
      end
   end

   assign ov_hit_cnt      = r_hit_cnt;
   assign ov_miss_cnt     = r_miss_cnt;
   assign ov_drop_req_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_flt_dmac_lookup_scheduler.sv
// ============================================================================
// tb_flt_dmac_lookup_scheduler
//   Directed bench with a behavioural RAM; FLT_LOOKUP_STAT_EN adds counter checks.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flt_dmac_lookup_scheduler;

   localparam int RAM_L = 2;

   localparam logic [56:0] ENT_A  = {48'h0011_2233_4455, 9'h004};
   localparam logic [56:0] ENT_B5 = {48'hAABB_CCDD_EEFF, 9'h002};
   localparam logic [56:0] ENT_B9 = {48'hAABB_CCDD_EEFF, 9'h008};
   localparam logic [56:0] ENT_C  = {48'h0102_0304_0506, 9'h000};
   localparam logic [56:0] ENT_D  = {48'hDEAD_BEEF_0001, 9'h010};
   localparam logic [56:0] ENT_E  = {48'h1234_5678_9ABC, 9'h1AB};
   localparam logic [56:0] ENT_F  = {48'h0000_0000_0001, 9'h001};
   localparam logic [56:0] ENT_X  = {48'h5555_AAAA_5555, 9'h033};

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_lookup_req = 1'b0;
   logic [47:0] iv_dmac = '0;
   logic        o_lookup_busy, o_lookup_ack, o_hit;
   logic [8:0]  ov_outport;
   logic        i_cfg_wr = 1'b0, i_cfg_rd = 1'b0;
   logic [4:0]  iv_cfg_addr = '0;
   logic [56:0] iv_cfg_wdata = '0;
   logic        o_cfg_rdata_valid;
   logic [56:0] ov_cfg_rdata;
   logic [4:0]  ov_ram_addr;
   logic [56:0] ov_ram_wdata;
   logic        o_ram_wr, o_ram_rd;
   logic [56:0] iv_ram_rdata;
`ifdef FLT_LOOKUP_STAT_EN
   logic        i_stat_clr = 1'b0;
   logic [31:0] ov_hit_cnt, ov_miss_cnt, ov_drop_req_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n_overlap = 0;
   logic [56:0] cfg_q[$];

   flt_dmac_lookup_scheduler #(.RAM_RD_LATENCY(RAM_L), .MISS_OUTPORT(9'h1FF)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_lookup_req(i_lookup_req), .iv_dmac(iv_dmac),
      .o_lookup_busy(o_lookup_busy), .o_lookup_ack(o_lookup_ack),
      .o_hit(o_hit), .ov_outport(ov_outport),
      .i_cfg_wr(i_cfg_wr), .i_cfg_rd(i_cfg_rd), .iv_cfg_addr(iv_cfg_addr),
      .iv_cfg_wdata(iv_cfg_wdata), .o_cfg_rdata_valid(o_cfg_rdata_valid),
      .ov_cfg_rdata(ov_cfg_rdata), .ov_ram_addr(ov_ram_addr),
      .ov_ram_wdata(ov_ram_wdata), .o_ram_wr(o_ram_wr), .o_ram_rd(o_ram_rd),
      .iv_ram_rdata(iv_ram_rdata)
`ifdef FLT_LOOKUP_STAT_EN
      , .i_stat_clr(i_stat_clr), .ov_hit_cnt(ov_hit_cnt),
      .ov_miss_cnt(ov_miss_cnt), .ov_drop_req_cnt(ov_drop_req_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   // Behavioural RAM: data valid RAM_L cycles after o_ram_rd is seen high
   logic [56:0] mem   [32]    = '{default: '0};
   logic [56:0] rpipe [RAM_L] = '{default: '0};
   always @(posedge i_clk) begin
      if (o_ram_wr) mem[ov_ram_addr] <= ov_ram_wdata;
      rpipe[0] <= o_ram_rd ? mem[ov_ram_addr] : 57'h0;
      for (int i = 1; i < RAM_L; i++) rpipe[i] <= rpipe[i-1];
   end
   assign iv_ram_rdata = rpipe[RAM_L-1];

   always @(negedge i_clk) begin
      if (o_ram_wr && o_ram_rd) n_overlap++;
      if (o_cfg_rdata_valid) cfg_q.push_back(ov_cfg_rdata);
   end

   typedef struct {
      logic [47:0] mac;
      logic        hit;
      logic [8:0]  port;
      int          lat;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [56:0] d);
      i_cfg_wr = 1'b1; iv_cfg_addr = a; iv_cfg_wdata = d;
      step();
      i_cfg_wr = 1'b0;
   endtask

   task automatic cfg_read(input logic [4:0] a, output int lat, output logic [56:0] d);
      i_cfg_rd = 1'b1; iv_cfg_addr = a;
      step();
      i_cfg_rd = 1'b0;
      lat = 1;
      while (!o_cfg_rdata_valid && lat < 20) begin step(); lat++; end
      if (!o_cfg_rdata_valid) lat = -1;
      d = ov_cfg_rdata;
   endtask

   // Returns ack latency (-1 on timeout), result, and post-ack sanity flags
   task automatic do_lookup(input logic [47:0] mac, output int lat, output logic hit,
                            output logic [8:0] port, output logic clean, output logic idle);
      i_lookup_req = 1'b1; iv_dmac = mac;
      step();
      i_lookup_req = 1'b0;
      lat = 1;
      while (!o_lookup_ack && lat < 100) begin step(); lat++; end
      if (!o_lookup_ack) lat = -1;
      hit  = o_hit;
      port = ov_outport;
      step();
      clean = !o_lookup_ack && !o_hit && (ov_outport == 9'd0);
      idle = 1'b0;
      for (int i = 0; i < 40 && !idle; i++) begin
         if (!o_lookup_busy) idle = 1'b1; else step();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic        hit, clean, idle;
      logic [8:0]  port;
      logic [56:0] d;
      int          acks;
      logic [56:0] exp_q[4];
`ifdef FLT_LOOKUP_STAT_EN
      logic [31:0] drop0;
`endif

      vecs[0] = '{48'h0011_2233_4455, 1'b1, 9'h004,  7};
      vecs[1] = '{48'hAABB_CCDD_EEFF, 1'b1, 9'h002,  9};
      vecs[2] = '{48'h0102_0304_0506, 1'b0, 9'h1FF, 35};
      vecs[3] = '{48'hDEAD_BEEF_0001, 1'b1, 9'h010, 24};
      vecs[4] = '{48'h1234_5678_9ABC, 1'b1, 9'h1AB, 35};
      vecs[5] = '{48'h0000_0000_0001, 1'b1, 9'h001,  4};
      vecs[6] = '{48'h7777_6666_5555, 1'b0, 9'h1FF, 35};
      vecs[7] = '{48'h0000_0000_0000, 1'b0, 9'h1FF, 35};

      repeat (3) step();
      check("rst_busy",  {63'd0, o_lookup_busy}, 64'd0);
      check("rst_ack",   {55'd0, o_lookup_ack, o_hit, ov_outport}, 64'd0);
      check("rst_ram",   {57'd0, o_ram_wr, o_ram_rd, ov_ram_addr}, 64'd0);
      check("rst_wdata", {7'd0, ov_ram_wdata}, 64'd0);
      check("rst_cfg",   {6'd0, o_cfg_rdata_valid, ov_cfg_rdata}, 64'd0);
      i_rst_n = 1'b1;
      step();

      cfg_write(5'd3, ENT_A);
      cfg_read(5'd3, lat, d);
      check("cfg_rd_lat",  lat, 64'd4);
      check("cfg_rd_data", {7'd0, d}, {7'd0, ENT_A});
      repeat (3) step();
      check("cfg_rd_hold", {7'd0, ov_cfg_rdata}, {7'd0, ENT_A});

      cfg_write(5'd5,  ENT_B5);
      cfg_write(5'd9,  ENT_B9);
      cfg_write(5'd12, ENT_C);
      cfg_write(5'd20, ENT_D);
      cfg_write(5'd31, ENT_E);
      cfg_write(5'd0,  ENT_F);

      // Simultaneous write and read: write lands, read vanishes
      cfg_q.delete();
      i_cfg_wr = 1'b1; i_cfg_rd = 1'b1; iv_cfg_addr = 5'd7; iv_cfg_wdata = ENT_X;
      step();
      i_cfg_wr = 1'b0; i_cfg_rd = 1'b0;
      repeat (8) step();
      check("wr_rd_drop_cnt", cfg_q.size(), 64'd0);
      cfg_read(5'd7, lat, d);
      check("wr_rd_data", {7'd0, d}, {7'd0, ENT_X});
      cfg_write(5'd7, 57'd0);
      step();

      for (int v = 0; v < 8; v++) begin
         do_lookup(vecs[v].mac, lat, hit, port, clean, idle);
         check($sformatf("v%0d_lat", v),  lat, vecs[v].lat);
         check($sformatf("v%0d_hit", v),  {63'd0, hit}, {63'd0, vecs[v].hit});
         check($sformatf("v%0d_port", v), {55'd0, port}, {55'd0, vecs[v].port});
         check($sformatf("v%0d_clean", v), {62'd0, clean, idle}, 64'd3);
         step();
      end

      // Four config reads steal four scan slots ahead of entry 20
      cfg_q.delete();
      exp_q = '{ENT_A, ENT_B5, ENT_B9, ENT_D};
      fork
         do_lookup(48'hDEAD_BEEF_0001, lat, hit, port, clean, idle);
         begin
            repeat (3) step();
            for (int k = 0; k < 4; k++) begin
               i_cfg_rd = 1'b1;
               iv_cfg_addr = (k == 0) ? 5'd3 : (k == 1) ? 5'd5 : (k == 2) ? 5'd9 : 5'd20;
               step();
            end
            i_cfg_rd = 1'b0;
         end
      join
      check("steal_lat",  lat, 64'd28);
      check("steal_port", {54'd0, hit, port}, {54'd0, 1'b1, 9'h010});
      check("steal_cnt",  cfg_q.size(), 64'd4);
      for (int k = 0; k < 4; k++)
         check($sformatf("steal_data%0d", k),
               (k < cfg_q.size()) ? {7'd0, cfg_q[k]} : 64'hDEAD, {7'd0, exp_q[k]});

      // Request while busy is ignored; scan result is unaffected
`ifdef FLT_LOOKUP_STAT_EN
      drop0 = ov_drop_req_cnt;
`endif
      fork
         do_lookup(48'h1234_5678_9ABC, lat, hit, port, clean, idle);
         begin
            repeat (10) step();
            i_lookup_req = 1'b1; iv_dmac = 48'h0011_2233_4455;
            step();
            i_lookup_req = 1'b0;
         end
      join
      check("busy_req_lat",  lat, 64'd35);
      check("busy_req_port", {55'd0, port}, {55'd0, 9'h1AB});
`ifdef FLT_LOOKUP_STAT_EN
      check("stat_drop_inc", ov_drop_req_cnt - drop0, 64'd1);
      check("stat_hit_nz",  {63'd0, ov_hit_cnt  != 32'd0}, 64'd1);
      check("stat_miss_nz", {63'd0, ov_miss_cnt != 32'd0}, 64'd1);
      i_stat_clr = 1'b1;
      step();
      i_stat_clr = 1'b0;
      check("stat_clr", {ov_hit_cnt, ov_miss_cnt | ov_drop_req_cnt}, 64'd0);
`endif
      step();

      // Reset mid-scan: no stale ack, then a fresh lookup behaves normally
      i_lookup_req = 1'b1; iv_dmac = 48'h1234_5678_9ABC;
      step();
      i_lookup_req = 1'b0;
      repeat (8) step();
      i_rst_n = 1'b0;
      #1;
      check("midrst_busy", {63'd0, o_lookup_busy}, 64'd0);
      check("midrst_out",  {52'd0, o_lookup_ack, o_hit, ov_outport, o_ram_rd, o_ram_wr},
            64'd0);
      check("midrst_cfg",  {6'd0, o_cfg_rdata_valid, ov_cfg_rdata}, 64'd0);
      repeat (2) step();
      i_rst_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 40; i++) begin
         if (o_lookup_ack) acks++;
         step();
      end
      check("midrst_stale_ack", acks, 64'd0);
      do_lookup(48'h0011_2233_4455, lat, hit, port, clean, idle);
      check("post_rst_lat",  lat, 64'd7);
      check("post_rst_port", {54'd0, hit, port}, {54'd0, 1'b1, 9'h004});
      check("post_rst_idle", {62'd0, clean, idle}, 64'd3);

      check("wr_rd_overlap", n_overlap, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
